// File: rtl/fifo64x8_fwft.sv
// fifo64x8_fwft: 8-entry x 64-bit first-word-fall-through FIFO.
// The head word is presented through an internal 8:1 mux selected by rd_ptr,
// so reads are zero-latency and writes become visible one cycle later.

// 64-bit 8:1 mux feeding the read port.
module mux64x8_1 #(
    parameter int WIDTH = 64,
    parameter int NIN   = 8
) (
    input  logic [NIN-1:0][WIDTH-1:0] din,
    input  logic [$clog2(NIN)-1:0]    sel,
    output logic [WIDTH-1:0]          dout
);
    // Plain indexed select; the storage registers drive it directly.
    always_comb begin
        dout = din[sel];
    end
endmodule

module fifo64x8_fwft #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [3:0]       count,
    output logic             ovf,
    output logic             udf
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [2:0]                  wr_ptr;
    logic [2:0]                  rd_ptr;
    logic [WIDTH-1:0]            mux_out;
    logic                        wr_ok;
    logic                        rd_ok;

    assign empty = (count == 4'd0);
    assign full  = (count == 4'd8);

    // Full blocks the write even if a read frees a slot in the same cycle;
    // empty blocks the read even if a write arrives (no bypass path).
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    mux64x8_1 #(.WIDTH(WIDTH), .NIN(DEPTH)) u_mux (
        .din  (mem),
        .sel  (rd_ptr),
        .dout (mux_out)
    );

    // Head word is forced to zero while empty so stale entries never leak out.
    assign rd_data = empty ? '0 : mux_out;

    // Storage write; the slot under wr_ptr takes the incoming word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '0;
        end else if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap 7->0 by natural 3-bit overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 3'd1;
            if (rd_ok) rd_ptr <= rd_ptr + 3'd1;
        end
    end

    // Occupancy kept explicitly; pointers alone cannot tell full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 4'd0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Error pulses flag the rejected request one cycle after it was made.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= wr_en && full;
            udf <= rd_en && empty;
        end
    end
endmodule

// File: tb/tb_fifo64x8_fwft.sv
// Directed bench for fifo64x8_fwft: inputs change 1ns after the rising edge,
// outputs are checked in the same settled window.
module tb_fifo64x8_fwft;
    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        ovf;
    logic        udf;

    int tests;
    int fails;

    fifo64x8_fwft dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf),
        .udf     (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land in the settled window after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 64'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'($urandom);
            rd_en   = 1'($urandom);
            wr_data = {$urandom, $urandom};
            step();
        end
        tests++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 || rd_data !== 64'h0 ||
            ovf !== 1'b0 || udf !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: empty=%b full=%b count=%0d rd_data=%h ovf=%b udf=%b, want 1 0 0 0 0 0",
                     empty, full, count, rd_data, ovf, udf);
        end
        idle_inputs();
        reset_n = 1'b1;
        step();
        step();
        tests++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 || rd_data !== 64'h0 ||
            ovf !== 1'b0 || udf !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: empty=%b full=%b count=%0d rd_data=%h ovf=%b udf=%b, want 1 0 0 0 0 0",
                     empty, full, count, rd_data, ovf, udf);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 64'(i);
            step();
        end
        idle_inputs();
        tests++;
        if (full !== 1'b1 || count !== 4'd8 || rd_data !== 64'h1 || empty !== 1'b0) begin
            fails++;
            $display("FAIL fill: full=%b count=%0d rd_data=%h empty=%b, want 1 8 1 0",
                     full, count, rd_data, empty);
        end
        for (int i = 1; i <= 8; i++) begin
            tests++;
            if (rd_data !== 64'(i) || count !== 4'(9 - i)) begin
                fails++;
                $display("FAIL drain[%0d]: rd_data=%h count=%0d, want %h %0d",
                         i, rd_data, count, 64'(i), 9 - i);
            end
            rd_en = 1'b1;
            step();
        end
        idle_inputs();
        tests++;
        if (empty !== 1'b1 || rd_data !== 64'h0 || count !== 4'd0) begin
            fails++;
            $display("FAIL drain_end: empty=%b rd_data=%h count=%0d, want 1 0 0", empty, rd_data, count);
        end
    endtask

    task automatic test_ovf_udf();
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 64'h10 + 64'(i);
            step();
        end
        wr_data = 64'hDEAD;
        step();
        idle_inputs();
        tests++;
        if (ovf !== 1'b1 || count !== 4'd8 || rd_data !== 64'h10) begin
            fails++;
            $display("FAIL ovf_pulse: ovf=%b count=%0d rd_data=%h, want 1 8 10", ovf, count, rd_data);
        end
        step();
        tests++;
        if (ovf !== 1'b0 || count !== 4'd8) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b count=%0d, want 0 8", ovf, count);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (rd_data !== 64'h10 + 64'(i)) begin
                fails++;
                $display("FAIL ovf_contents[%0d]: rd_data=%h, want %h", i, rd_data, 64'h10 + 64'(i));
            end
            rd_en = 1'b1;
            step();
        end
        // rd_en still high with the FIFO now empty: underflow
        step();
        rd_en = 1'b0;
        tests++;
        if (udf !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL udf_pulse: udf=%b count=%0d empty=%b, want 1 0 1", udf, count, empty);
        end
        step();
        tests++;
        if (udf !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL udf_clear: udf=%b count=%0d, want 0 0", udf, count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 64'hB0 + 64'(i);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 64'hA0 + 64'(i);
            step();
        end
        idle_inputs();
        tests++;
        if (count !== 4'd6) begin
            fails++;
            $display("FAIL wrap_count: count=%0d, want 6", count);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (rd_data !== 64'hA0 + 64'(i)) begin
                fails++;
                $display("FAIL wrap_order[%0d]: rd_data=%h, want %h", i, rd_data, 64'hA0 + 64'(i));
            end
            rd_en = 1'b1;
            step();
        end
        idle_inputs();
        tests++;
        if (empty !== 1'b1 || rd_data !== 64'h0) begin
            fails++;
            $display("FAIL wrap_end: empty=%b rd_data=%h, want 1 0", empty, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 64'hC0 + 64'(i);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = 64'hC3 + 64'(k);
            tests++;
            if (rd_data !== 64'hC0 + 64'(k)) begin
                fails++;
                $display("FAIL b2b_order[%0d]: rd_data=%h, want %h", k, rd_data, 64'hC0 + 64'(k));
            end
            step();
            tests++;
            if (count !== 4'd3) begin
                fails++;
                $display("FAIL b2b_count[%0d]: count=%0d, want 3", k, count);
            end
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rd_data !== 64'hCA + 64'(i)) begin
                fails++;
                $display("FAIL b2b_tail[%0d]: rd_data=%h, want %h", i, rd_data, 64'hCA + 64'(i));
            end
            rd_en = 1'b1;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_simul_edges();
        // full: read wins, write rejected
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 64'hE0 + 64'(i);
            step();
        end
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 64'hFF;
        step();
        idle_inputs();
        tests++;
        if (count !== 4'd7 || ovf !== 1'b1 || rd_data !== 64'hE1) begin
            fails++;
            $display("FAIL simul_full: count=%0d ovf=%b rd_data=%h, want 7 1 e1", count, ovf, rd_data);
        end
        for (int i = 1; i < 8; i++) begin
            tests++;
            if (rd_data !== 64'hE0 + 64'(i)) begin
                fails++;
                $display("FAIL simul_full_drain[%0d]: rd_data=%h, want %h", i, rd_data, 64'hE0 + 64'(i));
            end
            rd_en = 1'b1;
            step();
        end
        idle_inputs();
        // empty: write wins, read rejected, no bypass
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 64'h55;
        #1;
        tests++;
        if (rd_data !== 64'h0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL simul_empty_bypass: rd_data=%h empty=%b, want 0 1", rd_data, empty);
        end
        step();
        idle_inputs();
        tests++;
        if (count !== 4'd1 || udf !== 1'b1 || rd_data !== 64'h55) begin
            fails++;
            $display("FAIL simul_empty: count=%0d udf=%b rd_data=%h, want 1 1 55", count, udf, rd_data);
        end
        rd_en = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 64'h30 + 64'(i);
            step();
        end
        idle_inputs();
        tests++;
        if (count !== 4'd5 || rd_data !== 64'h30) begin
            fails++;
            $display("FAIL mid_pre: count=%0d rd_data=%h, want 5 30", count, rd_data);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (count !== 4'd0 || empty !== 1'b1 || rd_data !== 64'h0 || full !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: count=%0d empty=%b rd_data=%h full=%b, want 0 1 0 0",
                     count, empty, rd_data, full);
        end
        #1;
        reset_n = 1'b1;
        step();
        wr_en   = 1'b1;
        wr_data = 64'h77;
        step();
        idle_inputs();
        tests++;
        if (rd_data !== 64'h77 || count !== 4'd1) begin
            fails++;
            $display("FAIL mid_after: rd_data=%h count=%0d, want 77 1", rd_data, count);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_fill_drain();
        test_ovf_udf();
        test_wrap();
        test_back_to_back();
        test_simul_edges();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
